// File: rtl/adder_share_arbiter_pkg.sv
// Shared types and constants for the adder-sharing arbiter: default datapath
// width, requester-index width helper and the result-slot state encoding.
package adder_share_arbiter_pkg;

    localparam int DATA_W_DEF = 32;

    // A single requester still needs a 1-bit index field.
    function automatic int id_w(input int num_req);
        return (num_req <= 1) ? 1 : $clog2(num_req);
    endfunction

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/Adder.sv
// Plain DATA_W-bit adder shared by all requesters; the carry-out is dropped.
module Adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o
);

    assign sum_o = a_i + b_i;

endmodule

// File: rtl/rr_grant.sv
// Combinational round-robin picker: first set request at or above the
// pointer, wrapping to index 0. Produces a one-hot grant and its index.
module rr_grant #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [ID_W-1:0]    idx_o
);

    always_comb begin
        int   cand;
        logic found;
        // NOTE: every variable gets a default before any conditional write,
        // otherwise the idle paths would infer latches.
        cand  = 0;
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        if (en_i) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                cand = int'(ptr_i) + i;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                if (!found && req_i[cand]) begin
                    gnt_o[cand] = 1'b1;
                    idx_o       = ID_W'(cand);
                    found       = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Round-robin sharing of one adder between NUM_REQ requesters; the result,
// signed-overflow flag and requester id land in a one-entry valid/ready slot.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    parameter  int DATA_W  = DATA_W_DEF,
    parameter  int CNT_W   = 16,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] src1_i,
    input  logic [NUM_REQ*DATA_W-1:0] src2_i,
    output logic [NUM_REQ-1:0]        gnt_o,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [ID_W-1:0]           rsp_id_o,
    output logic [DATA_W-1:0]         rsp_sum_o,
    output logic                      rsp_ovf_o,
    output logic [CNT_W-1:0]          op_cnt_o
);

    slot_state_e       state_q, state_d;
    logic [ID_W-1:0]   ptr_q, ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              ovf_q, ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              can_issue;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              transfer;
    logic [DATA_W-1:0] op_a, op_b, add_sum;

    // Same-cycle drain-and-refill: a full slot being read frees it now.
    assign can_issue = (state_q == ST_EMPTY) || rsp_ready_i;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_grant (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .en_i  (can_issue && rst_i),
        .gnt_o (gnt),
        .idx_o (gnt_idx)
    );

    assign gnt_o    = gnt;
    assign transfer = |(gnt & req_i);
    assign op_a     = src1_i[int'(gnt_idx)*DATA_W +: DATA_W];
    assign op_b     = src2_i[int'(gnt_idx)*DATA_W +: DATA_W];

    Adder #(
        .WIDTH (DATA_W)
    ) u_adder (
        .a_i   (op_a),
        .b_i   (op_b),
        .sum_o (add_sum)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (transfer) begin
            state_d = ST_FULL;
            sum_d   = add_sum;
            ovf_d   = (op_a[DATA_W-1] == op_b[DATA_W-1]) &&
                      (add_sum[DATA_W-1] != op_a[DATA_W-1]);
            id_d    = gnt_idx;
            ptr_d   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            cnt_d   = cnt_q + CNT_W'(1);
        end else if (state_q == ST_FULL && rsp_ready_i) begin
            state_d = ST_EMPTY;
        end
    end

    // NOTE: state uses non-blocking assignments only; reset is synchronous
    // and clears every flop, including the data fields.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            id_q    <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rsp_valid_o = (state_q == ST_FULL);
    assign rsp_id_o    = id_q;
    assign rsp_sum_o   = sum_q;
    assign rsp_ovf_o   = ovf_q;
    assign op_cnt_o    = cnt_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed self-checking bench for adder_share_arbiter (NUM_REQ=4, CNT_W=4).
module tb_adder_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   req = '0;
    logic [NR*DW-1:0] src1 = '0;
    logic [NR*DW-1:0] src2 = '0;
    logic            ready = 1'b1;
    logic [NR-1:0]   gnt;
    logic            valid;
    logic [1:0]      id;
    logic [DW-1:0]   sum;
    logic            ovf;
    logic [CW-1:0]   cnt;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    adder_share_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .CNT_W   (CW)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
        .src1_i      (src1),
        .src2_i      (src2),
        .gnt_o       (gnt),
        .rsp_valid_o (valid),
        .rsp_ready_i (ready),
        .rsp_id_o    (id),
        .rsp_sum_o   (sum),
        .rsp_ovf_o   (ovf),
        .op_cnt_o    (cnt)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b);
        src1[k*DW +: DW] = a;
        src2[k*DW +: DW] = b;
    endtask

    initial begin
        // Reset held 3 cycles with all requests pending.
        rst = 1'b0; req = 4'b1111; ready = 1'b1;
        #1;
        check("rst_gnt_pre", gnt, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_gnt", gnt, 4'b0000);
            check("rst_valid", valid, 1'b0);
            check("rst_cnt", cnt, 4'd0);
        end
        check("rst_sum", sum, 32'd0);
        check("rst_id", id, 2'd0);
        check("rst_ovf", ovf, 1'b0);

        // First grant after release goes to requester 0; withdraw before edge.
        rst = 1'b1;
        #1;
        check("first_gnt", gnt, 4'b0001);
        req = 4'b0000;
        #1;
        check("idle_gnt", gnt, 4'b0000);

        // Single op from requester 2.
        set_ops(2, 32'h0000_0004, 32'h0040_0000);
        req = 4'b0100;
        #1;
        check("single_gnt", gnt, 4'b0100);
        step();
        req = 4'b0000;
        check("single_valid", valid, 1'b1);
        check("single_sum", sum, 32'h0040_0004);
        check("single_id", id, 2'd2);
        check("single_ovf", ovf, 1'b0);
        check("single_cnt", cnt, 4'd1);

        // Drain without refill.
        step();
        check("drain_valid", valid, 1'b0);

        // Signed overflow from requester 3 (pointer now 3 -> moves to 0).
        set_ops(3, 32'h7FFF_FFFF, 32'h0000_0001);
        req = 4'b1000;
        #1;
        check("ovf_gnt", gnt, 4'b1000);
        step();
        req = 4'b0000;
        check("ovf_sum", sum, 32'h8000_0000);
        check("ovf_flag", ovf, 1'b1);
        check("ovf_id", id, 2'd3);
        check("ovf_cnt", cnt, 4'd2);

        // Round robin, back-to-back with the slot still full.
        for (int k = 0; k < NR; k++) set_ops(k, 32'h1000 * (k + 1), k);
        req = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            #1;
            check("rr_gnt", gnt, 4'b0001 << i);
            step();
            check("rr_valid", valid, 1'b1);
            check("rr_id", id, i);
            check("rr_sum", sum, 32'h1000 * (i + 1) + i);
            check("rr_cnt", cnt, 3 + i);
        end
        req = 4'b0000;

        // Unsigned wrap: carry discarded, no signed overflow.
        set_ops(0, 32'hFFFF_FFFF, 32'h0000_0001);
        req = 4'b0001;
        #1;
        check("wrap_gnt", gnt, 4'b0001);
        step();
        check("wrap_sum", sum, 32'h0000_0000);
        check("wrap_ovf", ovf, 1'b0);
        check("wrap_cnt", cnt, 4'd7);

        // Fill slot with 0x10 from requester 2, then apply backpressure.
        set_ops(2, 32'h8, 32'h8);
        req = 4'b0100;
        #1;
        check("bp_fill_gnt", gnt, 4'b0100);
        step();
        check("bp_fill_sum", sum, 32'h10);
        ready = 1'b0;
        req = 4'b0010;
        set_ops(1, 32'h100, 32'h23);
        #1;
        check("bp_gnt0", gnt, 4'b0000);
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_gnt", gnt, 4'b0000);
            check("bp_valid", valid, 1'b1);
            check("bp_sum", sum, 32'h10);
            check("bp_id", id, 2'd2);
            check("bp_cnt", cnt, 4'd8);
        end
        ready = 1'b1;
        #1;
        check("bp_release_gnt", gnt, 4'b0010);
        step();
        req = 4'b0000;
        check("bp_new_sum", sum, 32'h123);
        check("bp_new_id", id, 2'd1);
        check("bp_new_cnt", cnt, 4'd9);

        // 16 transfers: pointer starts at 2, counter wraps through 0 back to 9.
        req = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            #1;
            check("cw_gnt", gnt, 4'b0001 << ((2 + i) % NR));
            step();
            check("cw_id", id, (2 + i) % NR);
            check("cw_cnt", cnt, (9 + i + 1) % 16);
        end

        // Reset while full: grant forced low, result discarded.
        rst = 1'b0;
        #1;
        check("mid_rst_gnt", gnt, 4'b0000);
        step();
        check("mid_rst_valid", valid, 1'b0);
        check("mid_rst_cnt", cnt, 4'd0);
        check("mid_rst_sum", sum, 32'd0);
        check("mid_rst_id", id, 2'd0);
        rst = 1'b1;
        #1;
        check("post_rst_gnt", gnt, 4'b0001);
        req = 4'b0000;
        step();
        check("post_rst_valid", valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adder_share_arbiter.md
Name: adder_share_arbiter

Overview:
- Shares one 32-bit adder datapath between NUM_REQ requesters (e.g. PC+4 increment, branch-target calculation, address generation).
- Round-robin grant; operands of the granted requester are muxed into the adder.
- Sum, signed-overflow flag and requester ID are registered into a one-entry output slot with a valid/ready handshake.
- Sits between the pipeline stages and the shared Adder instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, operand/sum width
- CNT_W, 16, width of completed-operation counter

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-low reset
- req_i  in  NUM_REQ  per-requester request, level; held until granted
- src1_i  in  NUM_REQ*DATA_W  flattened operand A; requester k at bits [k*DATA_W +: DATA_W]
- src2_i  in  NUM_REQ*DATA_W  flattened operand B, same packing
- gnt_o  out  NUM_REQ  one-hot grant, combinational; transfer = req_i[k] & gnt_o[k]
- rsp_valid_o  out  1  output slot holds a result
- rsp_ready_i  in  1  consumer accepts result this cycle
- rsp_id_o  out  ID_W  index of requester that produced the result; ID_W = clog2(NUM_REQ)
- rsp_sum_o  out  DATA_W  src1 + src2 modulo 2^DATA_W
- rsp_ovf_o  out  1  signed (two's-complement) overflow of that addition
- op_cnt_o  out  CNT_W  number of completed transfers, wraps

Behaviour:
- Reset (rst_i low at a clock edge) clears:
  - rsp_valid_o = 0, rsp_sum_o = 0, rsp_ovf_o = 0, rsp_id_o = 0
  - rr pointer = 0, op_cnt_o = 0
- gnt_o is forced to 0 whenever rst_i is low, regardless of state; reset mid-operation discards any held result.
- Slot states:
  - EMPTY (rsp_valid_o = 0)
  - FULL (rsp_valid_o = 1)
- can_issue = EMPTY | (FULL & rsp_ready_i), i.e. same-cycle drain-and-refill is allowed.
- Grant: if can_issue and any req_i set, gnt_o is one-hot on the first set req_i searching from the rr pointer upward with wrap-around (pointer, pointer+1, ..., NUM_REQ-1, 0, ...). Otherwise gnt_o = 0.
- gnt_o never asserts on a requester whose req_i is 0.
- On a transfer, at the next edge:
  - rsp_sum_o <= A+B
  - rsp_ovf_o <= (A[MSB]==B[MSB]) & (sum[MSB]!=A[MSB])
  - rsp_id_o <= k
  - rsp_valid_o <= 1
  - pointer <= (k+1) mod NUM_REQ
  - op_cnt_o increments
- Latency: result is visible exactly 1 cycle after the grant cycle. Throughput: 1 op/cycle while rsp_ready_i stays high.
- Drain without refill (FULL & rsp_ready_i & no transfer): rsp_valid_o <= 0. Data fields hold their last values (don't care).
- FULL & !rsp_ready_i: all result fields hold stable; gnt_o = 0; pointer does not move.
- Pointer changes only on a transfer; idle cycles do not advance it.
- Fairness: a continuously requesting requester is granted within NUM_REQ transfers.
- Counter: op_cnt_o wraps from 2^CNT_W-1 to 0, with no sticky flag.
- Carry-out beyond DATA_W is discarded.

Decomposition:
- Shared package holds:
  - DATA_W default, ID_W function (clog2)
  - slot-state encoding (ST_EMPTY = 1'b0, ST_FULL = 1'b1)
- One sub-module: rr_grant (pure combinational round-robin picker).
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- The adder itself is the existing Adder module, instantiated once inside this block. Overflow logic stays in this block.

Test Plan:
- Reset with req_i = 4'b1111 held and rst_i low for 3 cycles -> gnt_o = 0, rsp_valid_o = 0, op_cnt_o = 0 throughout. First grant after release goes to requester 0.
- Single op: req_i[2] = 1, src1 = 0x0000_0004, src2 = 0x0040_0000, rsp_ready_i = 1 -> gnt_o = 4'b0100 that cycle. Next cycle rsp_valid_o = 1, rsp_sum_o = 0x0040_0004, rsp_id_o = 2, rsp_ovf_o = 0, op_cnt_o = 1.
- Round-robin: req_i = 4'b1111 held, rsp_ready_i = 1, four cycles -> grants 0, 1, 2, 3 in order. rsp_id_o sequence 0, 1, 2, 3 on the following cycles, back-to-back.
- Backpressure: slot FULL with sum 0x10, rsp_ready_i = 0 for 5 cycles while req_i[1] = 1 -> gnt_o = 0, result fields stable. When rsp_ready_i returns to 1, gnt_o[1] asserts the same cycle and the new result appears the next cycle.
- Overflow/wrap: 0x7FFF_FFFF + 0x0000_0001 -> sum 0x8000_0000, ovf = 1. 0xFFFF_FFFF + 0x0000_0001 -> sum 0, ovf = 0.
- Counter wrap and reset mid-op: with CNT_W = 4, 16 transfers -> op_cnt_o returns to 0. Assert rst_i low while FULL -> rsp_valid_o = 0 at the next edge and the result is discarded.
